// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues imem requests, buffers up to two in-order
// responses, discards stale responses after a redirect and drives the IF/ID
// register towards decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_stage_if.master     imem,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    output logic [31:0]       inst_o,
    output logic [31:0]       pc_o,
    output logic              valid_o
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned XLEN  = 32;

    logic [XLEN-1:0]  fpc;
    logic [XLEN-1:0]  ent_pc   [DEPTH];
    logic [XLEN-1:0]  ent_inst [DEPTH];
    logic [DEPTH-1:0] ent_fill;
    logic             head;
    logic [1:0]       count;
    logic [1:0]       drop;

    logic             req;
    logic             grant;
    logic             pop;
    logic             unf0;
    logic             unf1;
    logic             fill_en;
    logic             fill_idx;
    logic             alloc_idx;
    logic [2:0]       occ;
    logic [1:0]       unf_after;
    logic [1:0]       count_nxt;
    logic [1:0]       drop_nxt;

    // Request, fill, pop and bookkeeping decisions for this cycle.
    // Occupancy is taken after this cycle's pop so a full buffer that is
    // draining can still issue, which sustains one instruction per cycle.
    always_comb begin
        unf0      = (count != 2'd0) && !ent_fill[head];
        unf1      = (count == 2'd2) && !ent_fill[~head];
        pop       = !stall_i && !redirect_i && (count != 2'd0) && ent_fill[head];
        occ       = 3'(count) - 3'(pop) + 3'(drop);
        req       = rst_n && !redirect_i && (occ < 3'd2);
        grant     = req && imem.imem_gnt_i;
        alloc_idx = head ^ count[0];
        fill_en   = imem.imem_rvalid_i && (drop == 2'd0) && (unf0 || unf1);
        fill_idx  = unf0 ? head : ~head;
        unf_after = 2'(unf0) + 2'(unf1) - 2'(fill_en);
        count_nxt = count + 2'(grant) - 2'(pop);
        drop_nxt  = drop - 2'(imem.imem_rvalid_i && (drop != 2'd0));
        if (redirect_i) begin
            drop_nxt = drop_nxt + unf_after;
        end
    end

    assign imem.imem_req_o  = req;
    assign imem.imem_addr_o = fpc;

    // Buffer payload storage; validity is tracked by count/ent_fill.
    always_ff @(posedge clk) begin
        if (!redirect_i) begin
            if (fill_en) begin
                ent_inst[fill_idx] <= imem.imem_rdata_i;
            end
            if (grant) begin
                ent_pc[alloc_idx] <= fpc;
            end
        end
    end

    // Fetch PC, buffer control, drop counter and IF/ID register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc      <= RESET_PC;
            count    <= 2'd0;
            head     <= 1'b0;
            drop     <= 2'd0;
            ent_fill <= '0;
            inst_o   <= NOP_INST;
            pc_o     <= RESET_PC;
            valid_o  <= 1'b0;
        end else begin
            drop <= drop_nxt;
            if (redirect_i) begin
                fpc      <= redirect_pc_i & ~32'd3;
                count    <= 2'd0;
                ent_fill <= '0;
                inst_o   <= NOP_INST;
                valid_o  <= 1'b0;
            end else begin
                if (fill_en) begin
                    ent_fill[fill_idx] <= 1'b1;
                end
                if (grant) begin
                    ent_fill[alloc_idx] <= 1'b0;
                    fpc                 <= fpc + 32'd4;
                end
                count <= count_nxt;
                head  <= head ^ pop;
                if (pop) begin
                    inst_o  <= ent_inst[head];
                    pc_o    <= ent_pc[head];
                    valid_o <= 1'b1;
                end else if (!stall_i) begin
                    inst_o  <= NOP_INST;
                    valid_o <= 1'b0;
                end
            end
        end
    end

endmodule
